// File: rtl/mul_share_arbiter_if.sv
// Request/response handshake bundle between the client blocks and the
// shared-multiplier arbiter. Operands and the result ride on flat buses;
// requester i owns slice [i*W +: W] of each operand bus.
interface mul_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_op1;
    logic [NREQ*W-1:0] req_op2;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [2*W-1:0]    rsp_res;

    // Client side: presents operands, takes results.
    modport master (
        output req_valid,
        output req_op1,
        output req_op2,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_res
    );

    // Arbiter side: accepts operands, returns results.
    modport slave (
        input  req_valid,
        input  req_op1,
        input  req_op2,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_res
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Shares one fixed-latency unsigned multiplier among NREQ requesters.
// Round-robin grant, one operation in flight, valid/ready on both the
// request and the response side. The multiplier operands are registered
// and held for the whole operation; the product is captured once the
// multiplier latency has elapsed and then held until the owner takes it.
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_share_arbiter_if.slave   bus,
    output logic [W-1:0]         mul_op1,
    output logic [W-1:0]         mul_op2,
    input  logic [2*W-1:0]       mul_res,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Rotating-priority search: first valid requester after 'last',
    // wrapping. Walks offsets from farthest to nearest so the nearest
    // hit is the one that sticks. MSB of the result flags a hit.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [IW-1:0]   last);
        logic [IW:0]   pick;
        logic [IW-1:0] idx;
        pick = {(IW + 1){1'b0}};
        for (int off = NREQ; off >= 1; off--) begin
            idx = IW'((int'(last) + off) % NREQ);
            if (valid[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Decode a requester index into a one-hot strobe vector.
    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = {NREQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [IW-1:0]     last_r;
    logic [IW-1:0]     gnt_r;
    logic [CW-1:0]     cnt_r;
    logic [W-1:0]      mul_op1_r;
    logic [W-1:0]      mul_op2_r;
    logic [2*W-1:0]    rsp_res_r;

    logic [IW:0]       pick_s;
    logic              pick_hit_s;
    logic [IW-1:0]     pick_idx_s;
    logic [NREQ-1:0]   req_ready_s;
    logic [NREQ-1:0]   rsp_valid_s;
    logic              accept_s;
    logic              capture_s;
    logic              release_s;

    assign pick_s     = rr_pick(bus.req_valid, last_r);
    assign pick_hit_s = pick_s[IW];
    assign pick_idx_s = pick_s[IW-1:0];

    // Next-state and handshake strobes; rst masks both handshakes so a
    // reset cycle never looks like an accept or a pending response.
    always_comb begin
        state_nxt_s = state_r;
        req_ready_s = {NREQ{1'b0}};
        rsp_valid_s = {NREQ{1'b0}};
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_hit_s && !rst) begin
                    req_ready_s = onehot(pick_idx_s);
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (!rst) begin
                    rsp_valid_s = onehot(gnt_r);
                end else begin
                    rsp_valid_s = {NREQ{1'b0}};
                end
                if (bus.rsp_ready[gnt_r]) begin
                    release_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, latency countdown, result capture and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r    <= IW'(NREQ - 1);
            gnt_r     <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            mul_op1_r <= {W{1'b0}};
            mul_op2_r <= {W{1'b0}};
            rsp_res_r <= {(2 * W){1'b0}};
        end else begin
            if (accept_s) begin
                mul_op1_r <= bus.req_op1[pick_idx_s * W +: W];
                mul_op2_r <= bus.req_op2[pick_idx_s * W +: W];
                gnt_r     <= pick_idx_s;
                cnt_r     <= CW'(MUL_LAT);
            end else if (state_r == ST_WAIT) begin
                if (capture_s) begin
                    rsp_res_r <= mul_res;
                end else begin
                    cnt_r <= cnt_r - CW'(1'b1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
            if (release_s) begin
                last_r <= gnt_r;
            end else begin
                last_r <= last_r;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_res   = rsp_res_r;
    assign mul_op1       = mul_op1_r;
    assign mul_op2       = mul_op2_r;
    assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter (NREQ=4, W=8, MUL_LAT=1) with a registered
// multiplier model. A transaction-level reference (who owns the multiplier,
// how many cycles since accept, which product is owed) predicts every output
// each cycle; directed phases add literal expectations on top of it.
module tb_mul_share_arbiter;

    logic        clk;
    logic        rst;
    logic [7:0]  mul_op1;
    logic [7:0]  mul_op2;
    logic [15:0] mul_res;
    logic        busy;

    mul_share_arbiter_if #(.NREQ(4), .W(8)) bus ();

    mul_share_arbiter #(.NREQ(4), .W(8), .MUL_LAT(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .mul_op1 (mul_op1),
        .mul_op2 (mul_op2),
        .mul_res (mul_res),
        .busy    (busy)
    );

    // One-cycle registered multiplier.
    always_ff @(posedge clk) begin
        mul_res <= 16'(mul_op1) * 16'(mul_op2);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int phase  = 0;
    int seq3[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First requester with valid set, searching upward from last+1 with wrap.
    function automatic int rr_index(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] rr_expect(input logic [3:0] v, input int last);
        int g;
        g = rr_index(v, last);
        if (g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // Reference model and per-cycle comparison.
    initial begin
        bit          m_known;
        bit          m_busy;
        int          m_owner, m_age, m_last;
        logic [7:0]  m_op1, m_op2;
        logic [15:0] m_prod, m_res;
        int          cycle, acc_cycle, prev_acc, acc_n, ret_n, last_phase, g;
        logic [3:0]  e_ready, e_rvalid;
        logic [15:0] e_res;
        m_known = 0; m_busy = 0; m_owner = 0; m_age = 0; m_last = 3;
        m_op1 = 8'h00; m_op2 = 8'h00; m_prod = 16'h0000; m_res = 16'h0000;
        cycle = 0; acc_cycle = 0; prev_acc = 0; acc_n = 0; ret_n = 0; last_phase = -1;
        forever begin
            @(negedge clk);
            cycle++;
            if (phase != last_phase) begin
                acc_n = 0;
                ret_n = 0;
                last_phase = phase;
            end
            if (m_known) begin
                e_ready  = (m_busy || rst) ? 4'b0000 : rr_expect(bus.req_valid, m_last);
                e_rvalid = (m_busy && m_age >= 3 && !rst) ? 4'(1 << m_owner) : 4'b0000;
                e_res    = (m_busy && m_age >= 3) ? m_prod : m_res;
                chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rvalid));
                chk("rsp_res",   32'(bus.rsp_res),   32'(e_res));
                chk("mul_op1",   32'(mul_op1),       32'(m_op1));
                chk("mul_op2",   32'(mul_op2),       32'(m_op2));
                chk("busy",      32'(busy),          32'(m_busy));
                if (phase == 1 && rst) begin
                    chk("reset_outputs_zero", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_res, busy}), 32'h0);
                    chk("reset_mul_ops_zero", 32'({mul_op1, mul_op2}), 32'h0);
                end
            end
            if (rst) begin
                m_known = 1; m_busy = 0; m_age = 0; m_last = 3;
                m_op1 = 8'h00; m_op2 = 8'h00; m_res = 16'h0000;
            end else if (m_known) begin
                if (!m_busy) begin
                    g = rr_index(bus.req_valid, m_last);
                    if (g >= 0) begin
                        m_busy  = 1;
                        m_owner = g;
                        m_age   = 1;
                        m_op1   = bus.req_op1[g*8 +: 8];
                        m_op2   = bus.req_op2[g*8 +: 8];
                        m_prod  = 16'(m_op1) * 16'(m_op2);
                        if (phase == 3 && acc_n < 5) chk("rr_order", 32'(g), 32'(seq3[acc_n]));
                        if (phase == 3 && acc_n > 0) chk("accept_spacing", 32'(cycle - prev_acc), 32'd4);
                        if (phase == 4 && acc_n == 0) chk("grant_req2", 32'(g), 32'd2);
                        if (phase == 5 && acc_n == 1) chk("grant_after_rst", 32'(g), 32'd0);
                        acc_cycle = cycle;
                        prev_acc  = cycle;
                        acc_n++;
                    end
                end else if (m_age >= 3 && bus.rsp_ready[m_owner]) begin
                    if (phase == 2) begin
                        chk("ff_times_ff", 32'(bus.rsp_res), 32'h0000FE01);
                        chk("accept_to_rsp", 32'(cycle - acc_cycle), 32'd3);
                    end
                    if (phase == 3) chk("h80_times_h02", 32'(bus.rsp_res), 32'h00000100);
                    if (phase == 4 && ret_n == 0) chk("held_rsp_cycles", 32'(cycle - acc_cycle), 32'd8);
                    if (phase == 6 && ret_n == 0) chk("zero_product", 32'(bus.rsp_res), 32'h0);
                    if (phase == 6 && ret_n == 1) chk("one_product", 32'(bus.rsp_res), 32'h1);
                    ret_n++;
                    m_busy = 0;
                    m_last = m_owner;
                    m_res  = m_prod;
                end else if (m_age < 3) begin
                    m_age++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_op1[i*8 +: 8] = a;
        bus.req_op2[i*8 +: 8] = b;
    endtask

    function automatic logic [7:0] rand_op();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    // Stimulus.
    initial begin
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 4'b0000;
        bus.req_op1   = 32'h0;
        bus.req_op2   = 32'h0;

        // Reset held with random inputs.
        phase = 1;
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 4'($urandom);
            bus.rsp_ready = 4'($urandom);
            bus.req_op1   = $urandom;
            bus.req_op2   = $urandom;
            cyc(1);
        end

        // Single request, 0xFF * 0xFF.
        phase = 2;
        rst = 1'b0;
        bus.rsp_ready = 4'b1111;
        set_ops(0, 8'hFF, 8'hFF);
        bus.req_valid = 4'b0001;
        cyc(1);
        bus.req_valid = 4'b0000;
        cyc(6);

        // All four requesting, priority restarted by a reset cycle.
        phase = 3;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ops(i, 8'h80, 8'h02);
        bus.req_valid = 4'b1111;
        cyc(20);
        bus.req_valid = 4'b0000;
        cyc(5);

        // Requester 2 with a response stalled for five cycles, requester 0 waiting.
        phase = 4;
        bus.rsp_ready = 4'b0000;
        set_ops(2, 8'h37, 8'hC5);
        set_ops(0, 8'h12, 8'h34);
        bus.req_valid = 4'b0100;
        cyc(1);
        bus.req_valid = 4'b0001;
        cyc(7);
        bus.rsp_ready = 4'b0100;
        cyc(1);
        bus.rsp_ready = 4'b1111;
        cyc(1);
        bus.req_valid = 4'b0000;
        cyc(6);

        // Reset one cycle after accepting requester 3.
        phase = 5;
        set_ops(3, 8'hA5, 8'h5A);
        bus.req_valid = 4'b1000;
        cyc(1);
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        cyc(1);
        bus.req_valid = 4'b0000;
        cyc(6);

        // Operand corner cases.
        phase = 6;
        set_ops(1, 8'h00, 8'hFF);
        bus.req_valid = 4'b0010;
        cyc(1);
        bus.req_valid = 4'b0000;
        cyc(5);
        set_ops(0, 8'h01, 8'h01);
        bus.req_valid = 4'b0001;
        cyc(1);
        bus.req_valid = 4'b0000;
        cyc(6);

        // Random traffic with occasional resets.
        phase = 7;
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.req_valid = 4'($urandom);
            bus.rsp_ready = 4'($urandom);
            for (int i = 0; i < 4; i++) set_ops(i, rand_op(), rand_op());
            cyc(1);
        end

        phase = 8;
        rst = 1'b0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 4'b1111;
        cyc(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
